// File: rtl/cbrt_poly_unit_if.sv
// Handshake and operand/result bundle for cbrt_poly_unit.
// The master side issues start_i with operands a_bi/b_bi; the slave side
// (the arithmetic core) returns busy_o, done_o, root_bo and y_bo.
// Widths follow the core: NR = ceil(WIDTH/3), y is never truncated.
interface cbrt_poly_unit_if #(
  parameter int WIDTH = 16,
  parameter int K_W   = 8
) ();

  localparam int NR = (WIDTH + 2) / 3;

  logic                      start_i;
  logic [WIDTH-1:0]          a_bi;
  logic [WIDTH-1:0]          b_bi;
  logic                      busy_o;
  logic                      done_o;
  logic [NR:0]               root_bo;
  logic [WIDTH+K_W+NR+1:0]   y_bo;

  modport master (
    output start_i,
    output a_bi,
    output b_bi,
    input  busy_o,
    input  done_o,
    input  root_bo,
    input  y_bo
  );

  modport slave (
    input  start_i,
    input  a_bi,
    input  b_bi,
    output busy_o,
    output done_o,
    output root_bo,
    output y_bo
  );

endinterface

// File: rtl/cbrt_poly_unit.sv
// cbrt_poly_unit: sequential evaluator of y = a*K + 2*cbrt(b).
// A shift-add multiplier (one bit of a per cycle, LSB first) and a
// digit-by-digit cube-root engine (two cycles per root bit) run side by
// side during RUN, which always lasts WIDTH cycles.
// Optional macro CBRT_ROUND_EN: adds the RND state so the root rounds to
// nearest (ties up) instead of floor; latency grows by one cycle.
module cbrt_poly_unit #(
  parameter int WIDTH = 16,
  parameter int K     = 3,
  parameter int K_W   = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  cbrt_poly_unit_if.slave   bus
);

  localparam int NR = (WIDTH + 2) / 3;
  localparam int PW = WIDTH + K_W;
  localparam int YW = WIDTH + K_W + NR + 2;
  localparam int TW = 3 * NR + 2;
  localparam int CW = $clog2(WIDTH + 1);
  localparam int SW = $clog2(3 * NR);

  localparam logic [PW-1:0] C_K      = PW'(K);
  localparam logic [TW-1:0] C_THREE  = TW'(3);
  localparam logic [TW-1:0] C_ONE    = TW'(1);
  localparam logic [NR:0]   C_YONE   = (NR+1)'(1);
  localparam logic [CW-1:0] C_CNTONE = CW'(1);
  localparam logic [CW-1:0] C_ROOTCY = CW'(2 * NR);
  localparam logic [CW-1:0] C_LASTCY = CW'(WIDTH - 1);
  localparam logic [SW-1:0] C_SHIFT0 = SW'(3 * (NR - 1));
  localparam logic [SW-1:0] C_SHSTEP = SW'(3);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
`ifdef CBRT_ROUND_EN
    S_RND,
`endif
    S_DONE
  } state_t;

  state_t            r_state;
  logic [CW-1:0]     r_cnt;
  logic [WIDTH-1:0]  r_aSh;
  logic [PW-1:0]     r_kSh;
  logic [PW-1:0]     r_prod;
  logic [WIDTH-1:0]  r_x;
  logic [NR:0]       r_y;
  logic [TW-1:0]     r_t;
  logic [SW-1:0]     r_shift;
  logic              r_busy;
  logic              r_done;
  logic [NR:0]       r_root;
  logic [YW-1:0]     r_yOut;

  logic [PW-1:0]     w_prodNext;
  logic              w_rootActive;
  logic [NR:0]       w_y2;
  logic [TW-1:0]     w_yExt;
  logic [TW-1:0]     w_tCand;
  logic              w_fits;
  logic [NR:0]       w_yNext;
  logic [WIDTH-1:0]  w_xNext;
  logic [TW-1:0]     w_tNext;
  logic [SW-1:0]     w_shiftNext;
  logic [NR:0]       w_yFinal;
  logic [PW-1:0]     w_prodFinal;
  logic [YW-1:0]     w_yOutNext;

`ifdef CBRT_ROUND_EN
  localparam int RW = 3 * NR + 6;

  logic [WIDTH-1:0]  r_b;
  logic [RW-1:0]     w_odd;
  logic [RW-1:0]     w_cube;
  logic [RW-1:0]     w_eightB;
  logic [NR:0]       w_yRnd;
`endif

  assign bus.busy_o  = r_busy;
  assign bus.done_o  = r_done;
  assign bus.root_bo = r_root;
  assign bus.y_bo    = r_yOut;

  // Multiplier step: add the current shifted copy of K when the next bit of a is set
  always_comb begin
    w_prodNext = r_prod;
    if (r_aSh[0]) begin
      w_prodNext = r_prod + r_kSh;
    end
  end

  // Cube-root step: even RUN cycles double y and form the trial term, odd cycles subtract it if it fits
  always_comb begin
    w_rootActive = (r_state == S_RUN) && (r_cnt < C_ROOTCY);
    w_y2         = {r_y[NR-1:0], 1'b0};
    w_yExt       = TW'(w_y2);
    w_tCand      = ((C_THREE * w_yExt * (w_yExt + C_ONE)) + C_ONE) << r_shift;
    w_fits       = (TW'(r_x) >= r_t);
    w_yNext      = r_y;
    w_xNext      = r_x;
    w_tNext      = r_t;
    w_shiftNext  = r_shift;
    if (w_rootActive) begin
      if (!r_cnt[0]) begin
        w_yNext = w_y2;
        w_tNext = w_tCand;
      end else begin
        if (w_fits) begin
          w_xNext = r_x - r_t[WIDTH-1:0];
          w_yNext = r_y + C_YONE;
        end
        w_shiftNext = r_shift - C_SHSTEP;
      end
    end
  end

`ifdef CBRT_ROUND_EN
  // Rounding test: bump the floor root when 8*b reaches (2y+1)^3, i.e. b >= (y+0.5)^3
  always_comb begin
    w_odd    = RW'({r_y, 1'b1});
    w_cube   = w_odd * w_odd * w_odd;
    w_eightB = RW'({r_b, 3'b000});
    w_yRnd   = r_y;
    if (w_eightB >= w_cube) begin
      w_yRnd = r_y + C_YONE;
    end
  end

  assign w_yFinal    = w_yRnd;
  assign w_prodFinal = r_prod;
`else
  assign w_yFinal    = w_yNext;
  assign w_prodFinal = w_prodNext;
`endif

  assign w_yOutNext = YW'(w_prodFinal) + YW'({w_yFinal, 1'b0});

  // Control FSM: owns all state, result and handshake registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_aSh   <= '0;
      r_kSh   <= '0;
      r_prod  <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_t     <= '0;
      r_shift <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_root  <= '0;
      r_yOut  <= '0;
`ifdef CBRT_ROUND_EN
      r_b     <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (bus.start_i) begin
            r_aSh   <= bus.a_bi;
            r_kSh   <= C_K;
            r_prod  <= '0;
            r_x     <= bus.b_bi;
            r_y     <= '0;
            r_t     <= '0;
            r_shift <= C_SHIFT0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
`ifdef CBRT_ROUND_EN
            r_b     <= bus.b_bi;
`endif
          end
        end

        S_RUN: begin
          r_aSh   <= r_aSh >> 1;
          r_kSh   <= r_kSh << 1;
          r_prod  <= w_prodNext;
          r_y     <= w_yNext;
          r_x     <= w_xNext;
          r_t     <= w_tNext;
          r_shift <= w_shiftNext;
          r_cnt   <= r_cnt + C_CNTONE;
          if (r_cnt == C_LASTCY) begin
`ifdef CBRT_ROUND_EN
            r_state <= S_RND;
`else
            r_state <= S_DONE;
            r_done  <= 1'b1;
            r_root  <= w_yFinal;
            r_yOut  <= w_yOutNext;
`endif
          end
        end

`ifdef CBRT_ROUND_EN
        S_RND: begin
          r_y     <= w_yRnd;
          r_state <= S_DONE;
          r_done  <= 1'b1;
          r_root  <= w_yFinal;
          r_yOut  <= w_yOutNext;
        end
`endif

        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cbrt_poly_unit.sv
// Self-checking bench for cbrt_poly_unit (WIDTH=16, K=3, K_W=8).
// Directed vectors from a table, hand-built sequences for ignored starts
// and mid-run reset, then random operands against a cube-root model.
// Honours CBRT_ROUND_EN for expected roots and latency.
module tb_cbrt_poly_unit;

  localparam int WIDTH = 16;
  localparam int K     = 3;
  localparam int K_W   = 8;
`ifdef CBRT_ROUND_EN
  localparam int LAT = 18;
`else
  localparam int LAT = 17;
`endif

  typedef struct {
    logic [63:0] root;
    logic [63:0] y;
  } exp_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [63:0] expRoot;
    logic [63:0] expY;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  exp_t sbQueue[$];
  int   nChecks = 0;
  int   nFails  = 0;

  // Free-running 10 ns clock
  always #5 clk = ~clk;

  cbrt_poly_unit_if #(.WIDTH(WIDTH), .K_W(K_W)) bus ();

  cbrt_poly_unit #(.WIDTH(WIDTH), .K(K), .K_W(K_W)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic exp_t refModel(input logic [15:0] a, input logic [15:0] b);
    exp_t   e;
    longint r  = 0;
    longint bb = longint'(b);
    while ((r + 1) * (r + 1) * (r + 1) <= bb) r++;
`ifdef CBRT_ROUND_EN
    if (8 * bb >= (2 * r + 1) * (2 * r + 1) * (2 * r + 1)) r++;
`endif
    e.root = 64'(r);
    e.y    = 64'(longint'(a) * K + 2 * r);
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b, input exp_t e);
    bus.start_i = 1'b1;
    bus.a_bi    = a;
    bus.b_bi    = b;
    sbQueue.push_back(e);
    tick();
    bus.start_i = 1'b0;
    bus.a_bi    = ~a;
    bus.b_bi    = b ^ 16'h5A5A;
  endtask

  task automatic waitResult(input string tag);
    int   cyc    = 1;
    bit   busyOk = 1'b1;
    exp_t e;
    while (bus.done_o !== 1'b1 && cyc < 40) begin
      if (bus.busy_o !== 1'b1) busyOk = 1'b0;
      tick();
      cyc++;
    end
    checkOutput({tag, " busy during run"}, 64'(busyOk), 64'd1);
    if (sbQueue.size() == 0) begin
      nChecks++;
      nFails++;
      $display("[TB] FAIL %s scoreboard: result with no expected entry", tag);
      return;
    end
    e = sbQueue.pop_front();
    if (bus.done_o !== 1'b1) begin
      checkOutput({tag, " done timeout"}, 64'(bus.done_o), 64'd1);
      return;
    end
    checkOutput({tag, " latency"}, 64'(cyc), 64'(LAT));
    checkOutput({tag, " busy at done"}, 64'(bus.busy_o), 64'd1);
    checkOutput({tag, " root"}, 64'(bus.root_bo), e.root);
    checkOutput({tag, " y"}, 64'(bus.y_bo), e.y);
    tick();
    checkOutput({tag, " done pulse width"}, 64'(bus.done_o), 64'd0);
    checkOutput({tag, " busy after done"}, 64'(bus.busy_o), 64'd0);
  endtask

  // Hard time bound so a stuck design still ends the run
  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got running, expected finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t vecs[11];
    exp_t e;
    bit   doneSeen;

    vecs[0]  = '{16'd2,      16'd27,     64'd3,  64'd12};
    vecs[1]  = '{16'd0,      16'd0,      64'd0,  64'd0};
    vecs[2]  = '{16'd5,      16'd1,      64'd1,  64'd17};
    vecs[4]  = '{16'hFFFF,   16'hFFFF,   64'd40, 64'd196685};
    vecs[5]  = '{16'd0,      16'd9,      64'd2,  64'd4};
    vecs[7]  = '{16'd1,      16'd8,      64'd2,  64'd7};
    vecs[8]  = '{16'd100,    16'd64,     64'd4,  64'd308};
    vecs[9]  = '{16'd7,      16'd1000,   64'd10, 64'd41};
`ifdef CBRT_ROUND_EN
    vecs[3]  = '{16'd0,      16'd26,     64'd3,  64'd6};
    vecs[6]  = '{16'd3,      16'd7,      64'd2,  64'd13};
    vecs[10] = '{16'd255,    16'd4095,   64'd16, 64'd797};
`else
    vecs[3]  = '{16'd0,      16'd26,     64'd2,  64'd4};
    vecs[6]  = '{16'd3,      16'd7,      64'd1,  64'd11};
    vecs[10] = '{16'd255,    16'd4095,   64'd15, 64'd795};
`endif

    rst         = 1'b1;
    bus.start_i = 1'b0;
    bus.a_bi    = '0;
    bus.b_bi    = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("reset busy", 64'(bus.busy_o), 64'd0);
    checkOutput("reset done", 64'(bus.done_o), 64'd0);
    checkOutput("reset y", 64'(bus.y_bo), 64'd0);
    checkOutput("reset root", 64'(bus.root_bo), 64'd0);
    tick();

    for (int i = 0; i < 11; i++) begin
      e.root = vecs[i].expRoot;
      e.y    = vecs[i].expY;
      applyStimulus(vecs[i].a, vecs[i].b, e);
      waitResult($sformatf("vec%0d", i));
    end

    repeat (3) tick();
    checkOutput("hold root", 64'(bus.root_bo), vecs[10].expRoot);
    checkOutput("hold y", 64'(bus.y_bo), vecs[10].expY);

    // Extra start pulses in cycle 5 and in the DONE cycle must be ignored
    e.root = 64'd3;
    e.y    = 64'd12;
    sbQueue.push_back(e);
    bus.start_i = 1'b1;
    bus.a_bi    = 16'd2;
    bus.b_bi    = 16'd27;
    tick();
    doneSeen = 1'b0;
    for (int cyc = 1; cyc <= 18; cyc++) begin
      bus.start_i = (cyc == 5 || cyc == LAT);
      bus.a_bi    = 16'd999;
      bus.b_bi    = 16'd5000;
      if (cyc < LAT && bus.done_o === 1'b1) doneSeen = 1'b1;
      if (cyc == LAT) begin
        checkOutput("ignore early done", 64'(doneSeen), 64'd0);
        checkOutput("ignore done", 64'(bus.done_o), 64'd1);
        e = sbQueue.pop_front();
        checkOutput("ignore root", 64'(bus.root_bo), e.root);
        checkOutput("ignore y", 64'(bus.y_bo), e.y);
      end
      if (cyc == LAT + 1) begin
        bus.start_i = 1'b0;
        checkOutput("ignore busy after", 64'(bus.busy_o), 64'd0);
      end
      tick();
    end
    bus.start_i = 1'b0;
    tick();
    checkOutput("ignore no restart", 64'(bus.busy_o), 64'd0);
    checkOutput("ignore root held", 64'(bus.root_bo), 64'd3);

    // Reset in cycle 8 of a run aborts it without a done pulse
    bus.start_i = 1'b1;
    bus.a_bi    = 16'd5;
    bus.b_bi    = 16'd1000;
    tick();
    bus.start_i = 1'b0;
    repeat (7) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("midreset busy", 64'(bus.busy_o), 64'd0);
    checkOutput("midreset done", 64'(bus.done_o), 64'd0);
    checkOutput("midreset y", 64'(bus.y_bo), 64'd0);
    checkOutput("midreset root", 64'(bus.root_bo), 64'd0);
    doneSeen = 1'b0;
    for (int cyc = 0; cyc < 25; cyc++) begin
      if (bus.done_o !== 1'b0) doneSeen = 1'b1;
      tick();
    end
    checkOutput("midreset no done", 64'(doneSeen), 64'd0);

    for (int n = 0; n < 1000; n++) begin
      logic [15:0] ra;
      logic [15:0] rb;
      ra = 16'($urandom);
      rb = (n % 4 == 0) ? 16'($urandom_range(0, 200)) : 16'($urandom);
      applyStimulus(ra, rb, refModel(ra, rb));
      waitResult($sformatf("rand%0d a=%0d b=%0d", n, ra, rb));
    end

    if (sbQueue.size() != 0) begin
      nChecks++;
      nFails++;
      $display("[TB] FAIL scoreboard drain: got %0d pending, expected 0", sbQueue.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
